// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from execute, performs word-only
// memory accesses (read-modify-write for sub-word stores), and holds the response
// until writeback accepts it.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic [3:0]            mem_rw_ctrl_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_err_o
);

  // Byte-address bits that reach memory; anything above wraps.
  localparam int unsigned AddrBits = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StStore, StResp} state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  accept;
  logic                  req_err;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:AddrBits];

  assign accept = req_valid_i && (state_q == StIdle);

  // Classify an incoming request as illegal funct3 or misaligned.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3_i)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr_i[0];
      3'b010:  req_err = |req_addr_i[1:0];
      3'b100:  req_err = req_we_i;
      3'b101:  req_err = req_we_i | req_addr_i[0];
      default: req_err = 1'b1;
    endcase
  end

  // Extract and extend the addressed lane from the read word.
  always_comb begin
    lane_b = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{lane_b[7] & ~funct3_q[2]}}, lane_b};
      2'b01:   load_val = {{16{lane_h[15] & ~funct3_q[2]}}, lane_h};
      default: load_val = mem_rdata_i;
    endcase
  end

  // Splice store data into the read word for sub-word stores.
  always_comb begin
    merged = mem_rdata_i;
    if (!funct3_q[0]) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (!req_we_i) begin
            state_d = StLoad;
          end else if (req_funct3_i == 3'b010) begin
            state_d = StStore;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad:  state_d = StResp;
      StRmwRd: state_d = StStore;
      StStore: state_d = StResp;
      StResp:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs; reset forces StIdle so the write strobe drops at once.
  always_comb begin
    req_ready_o   = (state_q == StIdle);
    rsp_valid_o   = (state_q == StResp);
    mem_rw_ctrl_o = 4'b0010;
    mem_wdata_o   = '0;
    if (state_q == StStore) begin
      mem_rw_ctrl_o = 4'b1010;
      mem_wdata_o   = wdata_q;
    end
  end

  // Datapath next-state: latch on accept, capture load result, capture merged word.
  always_comb begin
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      funct3_d   = req_funct3_i;
      addr_d     = req_addr_i[AddrBits-1:0];
      wdata_d    = req_wdata_i;
      rd_d       = req_rd_i;
      err_d      = req_err;
      rsp_data_d = '0;
    end
    if (state_q == StLoad) begin
      rsp_data_d = load_val;
    end
    if (state_q == StRmwRd) begin
      wdata_d = merged;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign mem_waddr_o = addr_q[AddrBits-1:2];
  assign mem_raddr_o = addr_q[AddrBits-1:2];
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rd_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic checked
// against a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic [3:0]  mem_rw_ctrl_o;
  logic [9:0]  mem_waddr_o;
  logic [9:0]  mem_raddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_err_o;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int          n_writes = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;
  logic [31:0] obs_data;
  logic        obs_err;

  load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_rd_i     (req_rd_i),
    .mem_rw_ctrl_o(mem_rw_ctrl_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_raddr_o  (mem_raddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_rd_o     (rsp_rd_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem[mem_raddr_o];

  always @(posedge clk_i) begin
    if (mem_rw_ctrl_o[3]) begin
      mem[mem_waddr_o] <= mem_wdata_o;
      n_writes <= n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-granular memory semantics; updates ref_mem for legal stores.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err,
                       output logic [31:0] data, output int lat);
    int          size, off, widx;
    logic [31:0] word;
    longint      v;
    bit          legal;
    off   = int'(addr % 4);
    widx  = int'((addr / 4) % 1024);
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal = (f3 <= 2) || (!we && (f3 == 4 || f3 == 5));
    err   = !legal || (off % size != 0);
    data  = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      word = ref_mem[widx];
      for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[widx] = word;
      lat = (size == 4) ? 2 : 3;
    end else begin
      v = (longint'(ref_mem[widx]) / (longint'(1) << (8*off))) % (longint'(1) << (8*size));
      if (f3 < 4 && size < 4 && v >= (longint'(1) << (8*size-1))) begin
        v = v - (longint'(1) << (8*size));
      end
      data = v[31:0];
      lat  = 2;
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int hold);
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat, lat, w0, widx;
    widx = int'((addr / 4) % 1024);
    model(we, f3, addr, wdata, exp_err, exp_data, exp_lat);
    @(negedge clk_i);
    check("ready_in_idle", {31'b0, req_ready_o}, 32'd1);
    w0           = n_writes;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_rd_i     = rd;
    rsp_ready_i  = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_wdata_i = $urandom;
    req_rd_i    = 5'($urandom);
    lat = 1;
    while (!rsp_valid_o && lat < 8) begin
      @(negedge clk_i);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_data", rsp_data_o, exp_data);
    check("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
    check("rsp_rd", {27'b0, rsp_rd_o}, {27'b0, rd});
    obs_data = rsp_data_o;
    obs_err  = rsp_err_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("hold_data", rsp_data_o, exp_data);
      check("hold_rd", {27'b0, rsp_rd_o}, {27'b0, rd});
      check("hold_not_ready", {31'b0, req_ready_o}, 32'd0);
    end
    // Offer a request during the handshake; it must not be taken.
    rsp_ready_i  = 1'b1;
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h0;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    check("no_accept_at_handshake", {31'b0, req_ready_o}, 32'd1);
    check("valid_dropped", {31'b0, rsp_valid_o}, 32'd0);
    check("write_count", n_writes - w0, (we && !exp_err) ? 32'd1 : 32'd0);
    check("mem_word", mem[widx], ref_mem[widx]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          w0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[2]       = 32'h8081_F2F3;
    ref_mem[2]   = 32'h8081_F2F3;
    mem[1]       = 32'h1122_3344;
    ref_mem[1]   = 32'h1122_3344;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    req_rd_i     = 5'h0;
    rsp_ready_i  = 1'b0;
    #2;
    check("reset_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("reset_data", rsp_data_o, 32'h0);
    check("reset_rd", {27'b0, rsp_rd_o}, 32'd0);
    check("reset_err", {31'b0, rsp_err_o}, 32'd0);
    check("reset_ctrl", {28'b0, mem_rw_ctrl_o}, 32'h2);
    check("reset_wdata", mem_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, req_ready_o}, 32'd1);

    // Word and sub-word loads from a known word.
    do_txn(1'b0, 3'b010, 32'h8, 32'h0, 5'd3, 0);
    check("lw_0x8", obs_data, 32'h8081_F2F3);
    do_txn(1'b0, 3'b000, 32'h9, 32'h0, 5'd4, 0);
    check("lb_0x9", obs_data, 32'hFFFF_FFF2);
    do_txn(1'b0, 3'b100, 32'h9, 32'h0, 5'd5, 0);
    check("lbu_0x9", obs_data, 32'h0000_00F2);
    do_txn(1'b0, 3'b010, 32'hFFFF_F008, 32'h0, 5'd6, 0);
    check("lw_wrap", obs_data, 32'h8081_F2F3);

    // Byte store merges into the existing word.
    do_txn(1'b1, 3'b000, 32'h6, 32'hDEAD_BEAA, 5'd7, 0);
    check("sb_mem", mem[1], 32'h11AA_3344);
    check("sb_data", obs_data, 32'h0);

    // Misaligned accesses error out without touching memory.
    do_txn(1'b0, 3'b001, 32'h3, 32'h0, 5'd8, 0);
    check("lh_misaligned_err", {31'b0, obs_err}, 32'd1);
    do_txn(1'b1, 3'b010, 32'h2, 32'h5555_5555, 5'd9, 0);
    check("sw_misaligned_err", {31'b0, obs_err}, 32'd1);
    check("sw_misaligned_mem", mem[0], ref_mem[0]);

    // Response held under backpressure.
    do_txn(1'b0, 3'b001, 32'hA, 32'h0, 5'd10, 5);
    check("lh_hold", obs_data, 32'hFFFF_8081);

    // Reset while an sh sits in STORE.
    @(negedge clk_i);
    w0           = n_writes;
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = 3'b001;
    req_addr_i   = 32'h12;
    req_wdata_i  = 32'h0000_BEEF;
    req_rd_i     = 5'd11;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("sh_in_store", {28'b0, mem_rw_ctrl_o}, 32'hA);
    rst_ni = 1'b0;
    #1;
    check("rst_ctrl", {28'b0, mem_rw_ctrl_o}, 32'h2);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_data", rsp_data_o, 32'h0);
    check("rst_rd", {27'b0, rsp_rd_o}, 32'd0);
    check("rst_err", {31'b0, rsp_err_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_no_write", n_writes - w0, 32'd0);
    check("rst_mem", mem[4], ref_mem[4]);
    rst_ni = 1'b1;
    #1;
    check("rst_release_ready", {31'b0, req_ready_o}, 32'd1);

    // Randomized traffic over a small window with random high address bits.
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      addr[11:2] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      do_txn(we, f3, addr, $urandom, 5'($urandom), $urandom_range(0, 2));
    end
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
